// File: rtl/exec_seq_pkg.sv
// rtl/exec_seq_pkg.sv - shared types and opcode constants for execute_sequencer (EXEC_MULDIV_EN adds MD_WAIT)
package exec_seq_pkg;

  typedef struct packed {
    logic [63:0] pc;
    logic [63:0] imm;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd;
    logic        jump_signal;
  } control_signals_struct;

`ifdef EXEC_MULDIV_EN
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXEC    = 2'd1,
    ST_MD_WAIT = 2'd2
  } exec_seq_state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1
  } exec_seq_state_t;
`endif

  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_OP32      = 7'b0111011;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  // M-extension ops are register-register ops with the MULDIV funct7
  function automatic logic is_muldiv(input control_signals_struct cs);
    return ((cs.opcode == OPC_OP) || (cs.opcode == OPC_OP32)) && (cs.funct7 == FUNCT7_MULDIV);
  endfunction

endpackage

// File: rtl/muldiv_wait_counter.sv
// rtl/muldiv_wait_counter.sv - mul/div wait counter, instantiated only under EXEC_MULDIV_EN
module muldiv_wait_counter (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] load_value,
  output logic       zero
);

  logic [3:0] count;

  // Load on issue of a mul/div op, otherwise count down to zero and stop
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= 4'd0;
    end else if (load) begin
      count <= load_value;
    end else if (count != 4'd0) begin
      count <= count - 4'd1;
    end
  end

  assign zero = (count == 4'd0);

endmodule

// File: rtl/execute_sequencer.sv
// rtl/execute_sequencer.sv - ID/EX and EX/MEM sequencing around the executor; EXEC_MULDIV_EN enables multi-cycle mul/div
module execute_sequencer
  import exec_seq_pkg::*;
#(
  parameter int MULDIV_LATENCY = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  id_valid,
  output logic                  id_ready,
  input  control_signals_struct id_control_signals,
  input  logic [63:0]           id_reg_a,
  input  logic [63:0]           id_reg_b,
  output logic                  ex_enable,
  output control_signals_struct ex_control_signals,
  output logic [63:0]           ex_reg_a,
  output logic [63:0]           ex_reg_b,
  output logic [63:0]           ex_pc,
  input  logic                  ex_done,
  input  logic [63:0]           ex_alu_data,
  input  logic [63:0]           ex_target,
  input  control_signals_struct ex_control_signals_in,
  output logic                  mem_valid,
  input  logic                  mem_ready,
  output logic [63:0]           mem_alu_data,
  output control_signals_struct mem_control_signals,
  output logic                  redirect_valid,
  output logic [63:0]           redirect_pc,
  output logic                  flush
);

  if (MULDIV_LATENCY < 2 || MULDIV_LATENCY > 15) begin : g_bad_latency
    $error("MULDIV_LATENCY must be within 2..15");
  end

  exec_seq_state_t state, state_next, issue_state;
  logic exec_slot;
  logic retire;
  logic taken;
  logic accept;

`ifdef EXEC_MULDIV_EN
  localparam logic [3:0] MD_LOAD = 4'(MULDIV_LATENCY - 1);
  logic md_zero;
  logic accept_md;

  assign accept_md   = accept && is_muldiv(id_control_signals);
  assign issue_state = is_muldiv(id_control_signals) ? ST_MD_WAIT : ST_EXEC;
  assign exec_slot   = (state == ST_EXEC) || ((state == ST_MD_WAIT) && md_zero);

  muldiv_wait_counter u_md_counter (
    .clk        (clk),
    .reset      (reset),
    .load       (accept_md),
    .load_value (MD_LOAD),
    .zero       (md_zero)
  );
`else
  assign issue_state = ST_EXEC;
  assign exec_slot   = (state == ST_EXEC);
`endif

  // The executor may only complete once the EX/MEM slot is free or draining
  assign retire         = exec_slot && ex_done && (!mem_valid || mem_ready);
  assign taken          = retire && ex_control_signals_in.jump_signal;
  assign ex_enable      = (state != ST_IDLE);
  assign id_ready       = !reset && ((state == ST_IDLE) || (retire && !ex_control_signals_in.jump_signal));
  assign accept         = id_valid && id_ready;
  assign redirect_valid = taken;
  assign flush          = taken;
  assign redirect_pc    = taken ? ex_target : 64'd0;
  assign ex_pc          = ex_control_signals.pc;

  // Next state: a new issue wins, a retire with nothing behind it empties the stage
  always_comb begin
    state_next = state;
    if (accept) begin
      state_next = issue_state;
    end else if (retire) begin
      state_next = ST_IDLE;
    end
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // ID/EX register: only loads on accept, so operands stay frozen while stalled
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_control_signals <= '0;
      ex_reg_a           <= 64'd0;
      ex_reg_b           <= 64'd0;
    end else if (accept) begin
      ex_control_signals <= id_control_signals;
      ex_reg_a           <= id_reg_a;
      ex_reg_b           <= id_reg_b;
    end
  end

  // EX/MEM register: a retire overwrites, otherwise a consumed entry empties
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_valid           <= 1'b0;
      mem_alu_data        <= 64'd0;
      mem_control_signals <= '0;
    end else if (retire) begin
      mem_valid           <= 1'b1;
      mem_alu_data        <= ex_alu_data;
      mem_control_signals <= ex_control_signals_in;
    end else if (mem_ready) begin
      mem_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_execute_sequencer.sv
// tb/tb_execute_sequencer.sv - directed self-checking bench for execute_sequencer
module tb_execute_sequencer;
  import exec_seq_pkg::*;

  logic                  clk;
  logic                  reset;
  logic                  id_valid;
  logic                  id_ready;
  control_signals_struct id_control_signals;
  logic [63:0]           id_reg_a;
  logic [63:0]           id_reg_b;
  logic                  ex_enable;
  control_signals_struct ex_control_signals;
  logic [63:0]           ex_reg_a;
  logic [63:0]           ex_reg_b;
  logic [63:0]           ex_pc;
  logic                  ex_done;
  logic [63:0]           ex_alu_data;
  logic [63:0]           ex_target;
  control_signals_struct ex_control_signals_in;
  logic                  mem_valid;
  logic                  mem_ready;
  logic [63:0]           mem_alu_data;
  control_signals_struct mem_control_signals;
  logic                  redirect_valid;
  logic [63:0]           redirect_pc;
  logic                  flush;

  int errors = 0;
  int checks = 0;

  execute_sequencer #(.MULDIV_LATENCY(4)) dut (
    .clk                   (clk),
    .reset                 (reset),
    .id_valid              (id_valid),
    .id_ready              (id_ready),
    .id_control_signals    (id_control_signals),
    .id_reg_a              (id_reg_a),
    .id_reg_b              (id_reg_b),
    .ex_enable             (ex_enable),
    .ex_control_signals    (ex_control_signals),
    .ex_reg_a              (ex_reg_a),
    .ex_reg_b              (ex_reg_b),
    .ex_pc                 (ex_pc),
    .ex_done               (ex_done),
    .ex_alu_data           (ex_alu_data),
    .ex_target             (ex_target),
    .ex_control_signals_in (ex_control_signals_in),
    .mem_valid             (mem_valid),
    .mem_ready             (mem_ready),
    .mem_alu_data          (mem_alu_data),
    .mem_control_signals   (mem_control_signals),
    .redirect_valid        (redirect_valid),
    .redirect_pc           (redirect_pc),
    .flush                 (flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Executor stand-in: adds operands, branch target = pc + imm, BEQ/JAL decide jump
  assign ex_done     = ex_enable;
  assign ex_alu_data = ex_reg_a + ex_reg_b;
  assign ex_target   = ex_control_signals.pc + ex_control_signals.imm;
  always_comb begin
    ex_control_signals_in = ex_control_signals;
    ex_control_signals_in.jump_signal = 1'b0;
    if (ex_control_signals.opcode == OPC_BRANCH) begin
      ex_control_signals_in.jump_signal = (ex_reg_a == ex_reg_b);
    end else if (ex_control_signals.opcode == OPC_JAL) begin
      ex_control_signals_in.jump_signal = 1'b1;
    end
  end

  function automatic control_signals_struct mk(input logic [63:0] pc, input logic [63:0] imm,
                                               input logic [6:0] opc, input logic [6:0] f7);
    control_signals_struct c;
    c        = '0;
    c.pc     = pc;
    c.imm    = imm;
    c.opcode = opc;
    c.funct7 = f7;
    return c;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input control_signals_struct cs, input logic [63:0] a, input logic [63:0] b);
    id_valid           = v;
    id_control_signals = cs;
    id_reg_a           = a;
    id_reg_b           = b;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic mid;
    @(negedge clk);
  endtask

  initial begin
    reset     = 1'b1;
    mem_ready = 1'b1;
    drive(1'b0, '0, 64'd0, 64'd0);
    tick;
    tick;
    check("rst_id_ready", id_ready, 0);
    check("rst_mem_valid", mem_valid, 0);
    check("rst_ex_enable", ex_enable, 0);
    check("rst_redirect", redirect_valid, 0);
    check("rst_flush", flush, 0);
    check("rst_mem_data", mem_alu_data, 0);
    check("rst_redirect_pc", redirect_pc, 0);
    reset = 1'b0;
    #1;
    check("idle_id_ready", id_ready, 1);

    // ADDI: rs1=10, imm=5
    drive(1'b1, mk(64'h0, 64'd5, 7'b0010011, 7'd0), 64'd10, 64'd5);
    mid;
    check("addi_ready", id_ready, 1);
    tick;
    drive(1'b0, '0, 64'd0, 64'd0);
    check("addi_ex_enable", ex_enable, 1);
    check("addi_ex_reg_a", ex_reg_a, 64'd10);
    check("addi_mem_valid_early", mem_valid, 0);
    tick;
    check("addi_mem_valid", mem_valid, 1);
    check("addi_mem_data", mem_alu_data, 64'd15);
    check("addi_idle", ex_enable, 0);
    tick;
    check("addi_drain", mem_valid, 0);

    // Three back-to-back adds
    drive(1'b1, mk(64'h0, 64'd0, OPC_OP, 7'd0), 64'd1, 64'd2);
    tick;
    drive(1'b1, mk(64'h4, 64'd0, OPC_OP, 7'd0), 64'd3, 64'd4);
    mid;
    check("b2b_ready1", id_ready, 1);
    tick;
    check("b2b_res1", mem_alu_data, 64'd3);
    drive(1'b1, mk(64'h8, 64'd0, OPC_OP, 7'd0), 64'd5, 64'd6);
    mid;
    check("b2b_ready2", id_ready, 1);
    tick;
    check("b2b_res2", mem_alu_data, 64'd7);
    drive(1'b0, '0, 64'd0, 64'd0);
    tick;
    check("b2b_res3", mem_alu_data, 64'd11);
    check("b2b_valid3", mem_valid, 1);
    tick;

    // BEQ taken: pc=0x100, imm=0x20
    drive(1'b1, mk(64'h100, 64'h20, OPC_BRANCH, 7'd0), 64'd7, 64'd7);
    tick;
    drive(1'b1, mk(64'h104, 64'd0, OPC_OP, 7'd0), 64'd1, 64'd1);
    mid;
    check("beq_redirect", redirect_valid, 1);
    check("beq_flush", flush, 1);
    check("beq_redirect_pc", redirect_pc, 64'h120);
    check("beq_refuse", id_ready, 0);
    tick;
    check("beq_retired", mem_valid, 1);
    check("beq_jump_retired", mem_control_signals.jump_signal, 1);
    check("beq_not_issued", ex_enable, 0);
    mid;
    check("beq_pulse_end", redirect_valid, 0);
    check("beq_ready_after", id_ready, 1);
    tick;
    drive(1'b0, '0, 64'd0, 64'd0);
    tick;
    check("post_beq_res", mem_alu_data, 64'd2);
    tick;

    // Back-pressure with EX/MEM full, then a deferred JAL redirect
    mem_ready = 1'b0;
    drive(1'b1, mk(64'h0, 64'd0, OPC_OP, 7'd0), 64'd100, 64'd1);
    tick;
    drive(1'b0, '0, 64'd0, 64'd0);
    tick;
    check("bp_full", mem_valid, 1);
    check("bp_first_data", mem_alu_data, 64'd101);
    drive(1'b1, mk(64'h200, 64'h40, OPC_JAL, 7'd0), 64'd200, 64'd2);
    tick;
    for (int i = 0; i < 3; i++) begin
      mid;
      check("bp_ex_enable", ex_enable, 1);
      check("bp_id_ready", id_ready, 0);
      check("bp_no_redirect", redirect_valid, 0);
      check("bp_idex_hold", ex_reg_a, 64'd200);
      check("bp_exmem_hold", mem_alu_data, 64'd101);
      tick;
    end
    mem_ready = 1'b1;
    mid;
    check("bp_jal_redirect", redirect_valid, 1);
    check("bp_jal_pc", redirect_pc, 64'h240);
    check("bp_jal_refuse", id_ready, 0);
    tick;
    drive(1'b0, '0, 64'd0, 64'd0);
    check("bp_retire_data", mem_alu_data, 64'd202);
    check("bp_retire_valid", mem_valid, 1);
    check("bp_after_jump_idle", ex_enable, 0);
    tick;
    check("bp_drain", mem_valid, 0);

    // MUL followed by ADD
    drive(1'b1, mk(64'h0, 64'd0, OPC_OP, FUNCT7_MULDIV), 64'd6, 64'd7);
    tick;
    drive(1'b1, mk(64'h4, 64'd0, OPC_OP, 7'd0), 64'd1, 64'd1);
`ifdef EXEC_MULDIV_EN
    for (int i = 0; i < 3; i++) begin
      mid;
      check("md_wait_refuse", id_ready, 0);
      check("md_wait_no_result", mem_valid, 0);
      check("md_wait_enable", ex_enable, 1);
      tick;
    end
`endif
    mid;
    check("md_accept_on_retire", id_ready, 1);
    tick;
    check("md_mem_valid", mem_valid, 1);
    check("md_mem_data", mem_alu_data, 64'd13);
    check("md_next_issued", ex_reg_a, 64'd1);
    drive(1'b0, '0, 64'd0, 64'd0);
    tick;
    check("md_next_result", mem_alu_data, 64'd2);
    tick;

    // Reset asserted while a MUL is in flight and EX/MEM is full
    mem_ready = 1'b0;
    drive(1'b1, mk(64'h0, 64'd0, OPC_OP, 7'd0), 64'd3, 64'd3);
    tick;
    drive(1'b1, mk(64'h0, 64'd0, OPC_OP, FUNCT7_MULDIV), 64'd6, 64'd7);
    tick;
    drive(1'b0, '0, 64'd0, 64'd0);
    check("mr_mem_full", mem_valid, 1);
    check("mr_mem_data", mem_alu_data, 64'd6);
    check("mr_busy", ex_enable, 1);
    #2;
    reset = 1'b1;
    #1;
    check("mr_ex_enable", ex_enable, 0);
    check("mr_mem_valid", mem_valid, 0);
    check("mr_mem_data0", mem_alu_data, 0);
    check("mr_id_ready", id_ready, 0);
    check("mr_redirect", redirect_valid, 0);
    check("mr_flush", flush, 0);
    check("mr_idex_clear", ex_reg_a, 0);
    tick;
    reset     = 1'b0;
    mem_ready = 1'b1;
    #1;
    check("mr_idle_ready", id_ready, 1);
    check("mr_idle_enable", ex_enable, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
